// File: rtl/mem_result_checker_pkg.sv
// Shared types and default constants for the end-of-run memory result checker.
// Pure declarations; no logic, no latency, no flow control.
package mem_result_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        LEN,
        SCAN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CHK_FIXED = 2'd0,
        CHK_PAIRS = 2'd1,
        CHK_NONE  = 2'd2
    } mode_t;

    localparam logic [15:0] DEF_FLAG_ADDR  = 16'hFFFF;
    localparam logic [31:0] DEF_FLAG_VALUE = 32'hFFFF_F000;
    localparam int unsigned DEF_MAX_CYCLES = 32'd10_000_000;

endpackage

// File: rtl/mem_result_checker_if.sv
// Bundle of control, DM snoop, DM/golden read and status signals of the checker.
// Wires only; read data is expected one cycle after the strobe, no backpressure.
interface mem_result_checker_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W:0]   chk_len;
    logic              mon_enable;
    logic              mon_write;
    logic [ADDR_W-1:0] mon_address;
    logic [DATA_W-1:0] mon_in;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              gold_en;
    logic [ADDR_W-1:0] gold_addr;
    logic [DATA_W-1:0] gold_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              mm_valid;
    logic [ADDR_W-1:0] mm_addr;
    logic [DATA_W-1:0] mm_got;
    logic [DATA_W-1:0] mm_exp;

    modport master (
        output start, mode, chk_len, mon_enable, mon_write, mon_address, mon_in,
               rd_data, gold_data,
        input  rd_en, rd_addr, gold_en, gold_addr, busy, done, pass, timeout,
               cycle_cnt, err_cnt, mm_valid, mm_addr, mm_got, mm_exp
    );

    modport slave (
        input  start, mode, chk_len, mon_enable, mon_write, mon_address, mon_in,
               rd_data, gold_data,
        output rd_en, rd_addr, gold_en, gold_addr, busy, done, pass, timeout,
               cycle_cnt, err_cnt, mm_valid, mm_addr, mm_got, mm_exp
    );
endinterface

// File: rtl/mem_result_checker_run_watchdog.sv
// Cycle budget counter: counts enabled cycles, flags the last budgeted cycle.
// Expiry is combinational from the count; no flow control.
module mem_result_checker_run_watchdog #(
    parameter int unsigned MAX_CYCLES = 1,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             expired
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_W'(MAX_CYCLES - 1));
endmodule

// File: rtl/mem_result_checker.sv
// End-of-run checker: waits for the finish-flag store or budget expiry, then scans DM against golden.
// One read pair issued per cycle, compared one cycle later; N words finish N+1 cycles after SCAN entry. No backpressure.
module mem_result_checker
    import mem_result_checker_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] FLAG_ADDR  = ADDR_W'(DEF_FLAG_ADDR),
    parameter logic [DATA_W-1:0] FLAG_VALUE = DATA_W'(DEF_FLAG_VALUE),
    parameter int unsigned       MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int                CNT_W      = 32,
    parameter int unsigned       CHECK_BASE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_result_checker_if.slave  bus
);
    localparam logic [ADDR_W:0]   MAX_LEN = (ADDR_W+1)'((64'd1 << ADDR_W) - 64'(CHECK_BASE));
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(CHECK_BASE);

    state_t            state, state_nxt;
    logic              hit, expired, start_acc, cnt_en, issue, mismatch;
    logic [ADDR_W:0]   idx, len_q, len_fixed, len_pairs;
    logic              len_wait, cmp_vld, timeout_q, mm_valid_q;
    logic [ADDR_W-1:0] issue_addr, cmp_addr, rd_addr_q, gold_addr_q, mm_addr_q;
    logic [ADDR_W-1:0] rd_addr, gold_addr;
    logic              rd_en, gold_en, busy, done;
    logic [DATA_W-1:0] mm_got_q, mm_exp_q;
    logic [CNT_W-1:0]  err_q, cycle_cnt;

    function automatic logic [ADDR_W:0] clip_len(input logic [ADDR_W:0] l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    assign hit = bus.mon_enable & bus.mon_write & (bus.mon_address == FLAG_ADDR)
               & (bus.mon_in == FLAG_VALUE);
    assign start_acc  = bus.start & ((state == IDLE) | (state == DONE));
    assign issue      = (state == SCAN) && (idx < len_q);
    assign issue_addr = BASE + idx[ADDR_W-1:0];
    assign len_fixed  = clip_len(bus.chk_len);
    assign len_pairs  = clip_len({bus.rd_data[ADDR_W-1:0], 1'b1});
    // Four-state inequality so unknown bits on either side are reported.
    assign mismatch   = cmp_vld && (bus.rd_data !== bus.gold_data);
    assign cnt_en     = (state == RUN) && (state_nxt == RUN);

    mem_result_checker_run_watchdog #(
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_acc),
        .en      (cnt_en),
        .cnt     (cycle_cnt),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_acc) state_nxt = RUN;
            RUN: begin
                // A flag hit on the expiry cycle still counts as completion.
                if (hit) begin
                    if (bus.mode == CHK_FIXED)      state_nxt = SCAN;
                    else if (bus.mode == CHK_PAIRS) state_nxt = LEN;
                    else                            state_nxt = DONE;
                end else if (expired) begin
                    state_nxt = DONE;
                end
            end
            LEN:  if (len_wait) state_nxt = SCAN;
            SCAN: if (!issue) state_nxt = DONE;
            DONE: if (start_acc) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_en     = 1'b0;
        gold_en   = 1'b0;
        rd_addr   = rd_addr_q;
        gold_addr = gold_addr_q;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            RUN: busy = 1'b1;
            LEN: begin
                busy = 1'b1;
                if (!len_wait) begin
                    rd_en   = 1'b1;
                    rd_addr = BASE;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (issue) begin
                    rd_en     = 1'b1;
                    gold_en   = 1'b1;
                    rd_addr   = issue_addr;
                    gold_addr = issue_addr;
                end
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            len_q       <= '0;
            len_wait    <= 1'b0;
            cmp_vld     <= 1'b0;
            cmp_addr    <= '0;
            rd_addr_q   <= '0;
            gold_addr_q <= '0;
            err_q       <= '0;
            timeout_q   <= 1'b0;
            mm_valid_q  <= 1'b0;
            mm_addr_q   <= '0;
            mm_got_q    <= '0;
            mm_exp_q    <= '0;
        end else begin
            rd_addr_q   <= rd_addr;
            gold_addr_q <= gold_addr;
            cmp_vld     <= issue;
            if (issue) cmp_addr <= issue_addr;
            mm_valid_q  <= mismatch;
            if (mismatch) begin
                mm_addr_q <= cmp_addr;
                mm_got_q  <= bus.rd_data;
                mm_exp_q  <= bus.gold_data;
            end
            if (start_acc) begin
                err_q     <= '0;
                timeout_q <= 1'b0;
            end else begin
                if (mismatch && (err_q != '1)) err_q <= err_q + CNT_W'(1);
                if ((state == RUN) && !hit && expired) timeout_q <= 1'b1;
            end
            len_wait <= (state == LEN) && !len_wait;
            case (state)
                RUN: if (hit) begin
                    idx   <= '0;
                    len_q <= len_fixed;
                end
                LEN:  if (len_wait) len_q <= len_pairs;
                SCAN: if (issue) idx <= idx + (ADDR_W+1)'(1);
                default: ;
            endcase
        end
    end

    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = rd_addr;
    assign bus.gold_en   = gold_en;
    assign bus.gold_addr = gold_addr;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = done & ~timeout_q & (err_q == '0);
    assign bus.timeout   = timeout_q;
    assign bus.cycle_cnt = cycle_cnt;
    assign bus.err_cnt   = err_q;
    assign bus.mm_valid  = mm_valid_q;
    assign bus.mm_addr   = mm_addr_q;
    assign bus.mm_got    = mm_got_q;
    assign bus.mm_exp    = mm_exp_q;
endmodule
